// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared softmax types, default widths and helpers
package softmax_pkg;

   localparam int SOFTMAX_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_STREAM = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } softmax_state_e;

   // Width able to index n entries, never narrower than one bit.
   function automatic int ctr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/softmax_value_buffer.sv
// rtl/softmax_value_buffer.sv - value register file, one write port, one async read port
module softmax_value_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2,
   parameter int ADDR_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/softmax_feeder.sv
// rtl/softmax_feeder.sv - buffers a weight vector, streams it to the softmax cell, holds the result
module softmax_feeder
   import softmax_pkg::*;
#(
   parameter int DATA_WIDTH    = SOFTMAX_DATA_WIDTH,
   parameter int WEIGHT_AMOUNT = 2,
   parameter int TIMEOUT       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] load_value,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic                  start,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] output_index,
   output logic [DATA_WIDTH-1:0] output_value,
   output logic                  output_enable,
   input  logic [DATA_WIDTH:0]   softmax_result,
   output logic [DATA_WIDTH-1:0] result_index,
   output logic                  result_valid,
   output logic                  result_error,
   input  logic                  result_ack
);

   localparam int FCW = $clog2(WEIGHT_AMOUNT + 1);
   localparam int TW  = ctr_width(TIMEOUT);
   localparam int AW  = ctr_width(WEIGHT_AMOUNT);

   softmax_state_e        state_q, state_d;
   logic [FCW-1:0]        fill_count_q, fill_count_d;
   logic [FCW-1:0]        stream_index_q, stream_index_d;
   logic [TW-1:0]         wait_count_q, wait_count_d;
   logic                  load_ready_q, load_ready_d;
   logic                  busy_q, busy_d;
   logic                  output_enable_q, output_enable_d;
   logic [DATA_WIDTH-1:0] output_index_q, output_index_d;
   logic [DATA_WIDTH-1:0] output_value_q, output_value_d;
   logic [DATA_WIDTH-1:0] result_index_q, result_index_d;
   logic                  result_valid_q, result_valid_d;
   logic                  result_error_q, result_error_d;

   logic                  buf_wr_en;
   logic [AW-1:0]         buf_rd_addr;
   logic [DATA_WIDTH-1:0] buf_rd_data;
   logic [FCW-1:0]        next_index;

   softmax_value_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (WEIGHT_AMOUNT),
      .ADDR_WIDTH (AW)
   ) u_buffer (
      .clk     (clk),
      .wr_en   (buf_wr_en),
      .wr_addr (AW'(fill_count_q)),
      .wr_data (load_value),
      .rd_addr (buf_rd_addr),
      .rd_data (buf_rd_data)
   );

   // Read address looks one entry ahead so the registered pair lands with its index.
   assign next_index  = stream_index_q + FCW'(1);
   assign buf_rd_addr = (state_q == ST_STREAM) ? AW'(next_index) : '0;

   always_comb begin
      state_d         = state_q;
      fill_count_d    = fill_count_q;
      stream_index_d  = stream_index_q;
      wait_count_d    = wait_count_q;
      result_index_d  = result_index_q;
      result_valid_d  = result_valid_q;
      result_error_d  = result_error_q;
      output_enable_d = 1'b0;
      output_index_d  = '0;
      output_value_d  = '0;
      buf_wr_en       = 1'b0;

      case (state_q)
         ST_FILL: begin
            if (load_valid && load_ready_q) begin
               buf_wr_en    = 1'b1;
               fill_count_d = fill_count_q + FCW'(1);
            end else if (start && (fill_count_q == FCW'(WEIGHT_AMOUNT))) begin
               state_d         = ST_STREAM;
               stream_index_d  = '0;
               output_enable_d = 1'b1;
               output_value_d  = buf_rd_data;
            end
         end
         ST_STREAM: begin
            if (stream_index_q == FCW'(WEIGHT_AMOUNT - 1)) begin
               state_d      = ST_WAIT;
               wait_count_d = '0;
            end else begin
               stream_index_d  = next_index;
               output_enable_d = 1'b1;
               output_index_d  = DATA_WIDTH'(next_index);
               output_value_d  = buf_rd_data;
            end
         end
         ST_WAIT: begin
            // A valid result on the final wait cycle takes priority over the timeout.
            if (softmax_result[DATA_WIDTH]) begin
               state_d        = ST_DONE;
               result_index_d = softmax_result[DATA_WIDTH-1:0];
               result_error_d = 1'b0;
               result_valid_d = 1'b1;
            end else if (wait_count_q == TW'(TIMEOUT - 1)) begin
               state_d        = ST_DONE;
               result_index_d = '0;
               result_error_d = 1'b1;
               result_valid_d = 1'b1;
            end else begin
               wait_count_d = wait_count_q + TW'(1);
            end
         end
         ST_DONE: begin
            if (result_ack) begin
               state_d        = ST_FILL;
               result_valid_d = 1'b0;
               result_error_d = 1'b0;
               fill_count_d   = '0;
            end
         end
         default: state_d = ST_FILL;
      endcase

      load_ready_d = (state_d == ST_FILL) && (fill_count_d < FCW'(WEIGHT_AMOUNT));
      busy_d       = (state_d == ST_STREAM) || (state_d == ST_WAIT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_FILL;
         fill_count_q    <= '0;
         stream_index_q  <= '0;
         wait_count_q    <= '0;
         load_ready_q    <= 1'b1;
         busy_q          <= 1'b0;
         output_enable_q <= 1'b0;
         output_index_q  <= '0;
         output_value_q  <= '0;
         result_index_q  <= '0;
         result_valid_q  <= 1'b0;
         result_error_q  <= 1'b0;
      end else begin
         state_q         <= state_d;
         fill_count_q    <= fill_count_d;
         stream_index_q  <= stream_index_d;
         wait_count_q    <= wait_count_d;
         load_ready_q    <= load_ready_d;
         busy_q          <= busy_d;
         output_enable_q <= output_enable_d;
         output_index_q  <= output_index_d;
         output_value_q  <= output_value_d;
         result_index_q  <= result_index_d;
         result_valid_q  <= result_valid_d;
         result_error_q  <= result_error_d;
      end
   end

   assign load_ready    = load_ready_q;
   assign busy          = busy_q;
   assign output_enable = output_enable_q;
   assign output_index  = output_index_q;
   assign output_value  = output_value_q;
   assign result_index  = result_index_q;
   assign result_valid  = result_valid_q;
   assign result_error  = result_error_q;

endmodule

// File: tb/tb_softmax_feeder.sv
// tb/tb_softmax_feeder.sv - directed scoreboard bench for softmax_feeder
module tb_softmax_feeder;

   localparam int DW = 32;
   localparam int WA = 2;
   localparam int TO = 8;

   typedef struct {
      logic [DW-1:0] idx;
      logic [DW-1:0] val;
   } pair_t;

   typedef struct {
      logic [DW-1:0] idx;
      logic          err;
   } res_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] load_value;
   logic          load_valid;
   logic          load_ready;
   logic          start;
   logic          busy;
   logic [DW-1:0] output_index;
   logic [DW-1:0] output_value;
   logic          output_enable;
   logic [DW:0]   softmax_result;
   logic [DW-1:0] result_index;
   logic          result_valid;
   logic          result_error;
   logic          result_ack;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] model_buf [WA];
   int            model_fill;
   pair_t         exp_pairs[$];
   res_t          exp_res[$];

   softmax_feeder #(
      .DATA_WIDTH    (DW),
      .WEIGHT_AMOUNT (WA),
      .TIMEOUT       (TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .load_value     (load_value),
      .load_valid     (load_valid),
      .load_ready     (load_ready),
      .start          (start),
      .busy           (busy),
      .output_index   (output_index),
      .output_value   (output_value),
      .output_enable  (output_enable),
      .softmax_result (softmax_result),
      .result_index   (result_index),
      .result_valid   (result_valid),
      .result_error   (result_error),
      .result_ack     (result_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic int argmax();
      int b = 0;
      for (int i = 1; i < WA; i++) begin
         if (model_buf[i] > model_buf[b]) b = i;
      end
      return b;
   endfunction

   task automatic load(input logic [DW-1:0] v);
      chk("load_ready", 64'(load_ready), 64'(model_fill < WA));
      if (model_fill < WA) begin
         model_buf[model_fill] = v;
         model_fill++;
      end
      load_value = v;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      load_value = '0;
   endtask

   task automatic do_start();
      if (model_fill == WA) begin
         for (int i = 0; i < WA; i++) exp_pairs.push_back('{idx: DW'(i), val: model_buf[i]});
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic expect_stream();
      int    got = 0;
      pair_t p;
      for (int c = 0; c < 4 * WA; c++) begin
         if (output_enable) begin
            if (exp_pairs.size() == 0) begin
               chk("stream_extra_pair", 64'(1), 64'(0));
            end else begin
               p = exp_pairs.pop_front();
               chk("stream_index", 64'(output_index), 64'(p.idx));
               chk("stream_value", 64'(output_value), 64'(p.val));
            end
            got++;
         end else if (got > 0) begin
            break;
         end
         @(negedge clk);
      end
      chk("stream_len", 64'(got), 64'(WA));
      chk("after_stream_enable", 64'(output_enable), 64'(0));
      chk("after_stream_index", 64'(output_index), 64'(0));
      chk("after_stream_value", 64'(output_value), 64'(0));
      chk("wait_busy", 64'(busy), 64'(1));
   endtask

   task automatic wait_result();
      int   n = 0;
      res_t r;
      while (!result_valid && n < 4 * TO) begin
         @(negedge clk);
         n++;
      end
      chk("result_valid_seen", 64'(result_valid), 64'(1));
      if (exp_res.size() == 0) begin
         chk("result_queue_empty", 64'(1), 64'(0));
      end else begin
         r = exp_res.pop_front();
         chk("result_index", 64'(result_index), 64'(r.idx));
         chk("result_error", 64'(result_error), 64'(r.err));
      end
      chk("done_busy", 64'(busy), 64'(0));
   endtask

   task automatic cell_respond(input int delay);
      int a;
      a = argmax();
      exp_res.push_back('{idx: DW'(a), err: 1'b0});
      repeat (delay) @(negedge clk);
      softmax_result = {1'b1, DW'(a)};
      @(negedge clk);
      softmax_result = '0;
   endtask

   task automatic ack();
      result_ack = 1'b1;
      @(negedge clk);
      result_ack = 1'b0;
      chk("ack_valid", 64'(result_valid), 64'(0));
      chk("ack_error", 64'(result_error), 64'(0));
      chk("ack_load_ready", 64'(load_ready), 64'(1));
      model_fill = 0;
   endtask

   initial begin
      int n;
      rst            = 1'b1;
      load_value     = '0;
      load_valid     = 1'b0;
      start          = 1'b0;
      softmax_result = '0;
      result_ack     = 1'b0;
      model_fill     = 0;

      repeat (2) @(negedge clk);
      chk("rst_load_ready", 64'(load_ready), 64'(1));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_enable", 64'(output_enable), 64'(0));
      chk("rst_index", 64'(output_index), 64'(0));
      chk("rst_value", 64'(output_value), 64'(0));
      chk("rst_result_index", 64'(result_index), 64'(0));
      chk("rst_result_valid", 64'(result_valid), 64'(0));
      chk("rst_result_error", 64'(result_error), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // Start with a half-full buffer is ignored; extra load when full is refused.
      load(32'd5);
      do_start();
      chk("partial_start_enable", 64'(output_enable), 64'(0));
      chk("partial_start_busy", 64'(busy), 64'(0));
      @(negedge clk);
      chk("partial_start_enable2", 64'(output_enable), 64'(0));
      load(32'd7);
      load(32'd99);
      chk("full_load_ready", 64'(load_ready), 64'(0));
      do_start();
      expect_stream();
      cell_respond(0);
      wait_result();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("held_valid", 64'(result_valid), 64'(1));
         chk("held_index", 64'(result_index), 64'(1));
      end
      ack();

      // Load 2,1 and stream with a responding cell.
      load(32'd2);
      load(32'd1);
      do_start();
      expect_stream();
      cell_respond(2);
      wait_result();
      ack();

      // Timeout; a valid result outside WAIT must be ignored.
      softmax_result = {1'b1, 32'd1};
      load(32'd3);
      load(32'd4);
      do_start();
      expect_stream();
      softmax_result = '0;
      exp_res.push_back('{idx: '0, err: 1'b1});
      n = 0;
      while (!result_valid && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("timeout_wait_cycles", 64'(n), 64'(TO));
      wait_result();
      ack();

      // Valid result arriving on the last wait cycle beats the timeout.
      load(32'd1);
      load(32'd6);
      do_start();
      expect_stream();
      repeat (TO - 1) @(negedge clk);
      chk("pre_timeout_valid", 64'(result_valid), 64'(0));
      softmax_result = {1'b1, 32'd1};
      exp_res.push_back('{idx: 32'd1, err: 1'b0});
      @(negedge clk);
      softmax_result = '0;
      wait_result();
      ack();

      // Reset in the middle of a stream.
      load(32'd6);
      load(32'd8);
      do_start();
      chk("mid_enable", 64'(output_enable), 64'(1));
      chk("mid_index", 64'(output_index), 64'(0));
      chk("mid_value", 64'(output_value), 64'(6));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_pairs.delete();
      model_fill = 0;
      chk("mid_rst_enable", 64'(output_enable), 64'(0));
      chk("mid_rst_index", 64'(output_index), 64'(0));
      chk("mid_rst_load_ready", 64'(load_ready), 64'(1));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      do_start();
      chk("post_rst_start_enable", 64'(output_enable), 64'(0));
      chk("post_rst_start_busy", 64'(busy), 64'(0));
      load(32'd9);
      load(32'd4);
      do_start();
      expect_stream();
      cell_respond(1);
      wait_result();
      ack();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
